// File: rtl/regfile_pkg.sv
// Shared FunSel encoding for the parametrised register file.
package regfile_pkg;

  localparam int FS_W = 3;

  localparam logic [FS_W-1:0] FS_DEC  = 3'b000;
  localparam logic [FS_W-1:0] FS_INC  = 3'b001;
  localparam logic [FS_W-1:0] FS_LOAD = 3'b010;
  localparam logic [FS_W-1:0] FS_CLR  = 3'b011;
  localparam logic [FS_W-1:0] FS_SHL  = 3'b100;
  localparam logic [FS_W-1:0] FS_SHR  = 3'b101;
  localparam logic [FS_W-1:0] FS_ROL  = 3'b110;
  localparam logic [FS_W-1:0] FS_HOLD = 3'b111;

endpackage

// File: rtl/reg_cell.sv
// One WIDTH-bit register plus its sticky wrap/saturation flag.
// REGFILE_SAT_EN: INC/DEC saturate instead of wrapping around.
module reg_cell
  import regfile_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             En,
  input  logic [FS_W-1:0]  FunSel,
  input  logic [WIDTH-1:0] I,
  output logic [WIDTH-1:0] Q,
  output logic             Wrap
);

  logic [WIDTH-1:0] nextQ;
  logic             nextWrap;
  logic             qOnes;
  logic             qZero;

  assign qOnes = &Q;
  assign qZero = ~|Q;

  always_comb begin
    nextQ    = Q;
    nextWrap = Wrap;
    unique case (FunSel)
      FS_DEC: begin
        nextQ = Q - WIDTH'(1);
        if (qZero) begin
          nextWrap = 1'b1;
`ifdef REGFILE_SAT_EN
          nextQ    = Q;
`endif
        end
      end
      FS_INC: begin
        nextQ = Q + WIDTH'(1);
        if (qOnes) begin
          nextWrap = 1'b1;
`ifdef REGFILE_SAT_EN
          nextQ    = Q;
`endif
        end
      end
      FS_LOAD: nextQ = I;
      // CLEAR is the only operation that drops the sticky flag.
      FS_CLR: begin
        nextQ    = '0;
        nextWrap = 1'b0;
      end
      FS_SHL:  nextQ = {Q[WIDTH-2:0], 1'b0};
      FS_SHR:  nextQ = {1'b0, Q[WIDTH-1:1]};
      FS_ROL:  nextQ = {Q[WIDTH-2:0], Q[WIDTH-1]};
      default: nextQ = Q;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      Q    <= '0;
      Wrap <= 1'b0;
    end else if (En) begin
      Q    <= nextQ;
      Wrap <= nextWrap;
    end
  end

endmodule

// File: rtl/reg_file_param.sv
// NREG x WIDTH register file with two combinational read ports, zero decode and wrap flags.
// REGFILE_SAT_EN (see reg_cell) selects saturating INC/DEC.
module reg_file_param
  import regfile_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREG  = 4
) (
  input  logic                    Clk,
  input  logic                    Rst_n,
  input  logic [WIDTH-1:0]        I,
  input  logic                    E,
  input  logic [NREG-1:0]         RegSel,
  input  logic [FS_W-1:0]         FunSel,
  input  logic [$clog2(NREG)-1:0] OutASel,
  input  logic [$clog2(NREG)-1:0] OutBSel,
  output logic [WIDTH-1:0]        OutA,
  output logic [WIDTH-1:0]        OutB,
  output logic [NREG-1:0]         Zero,
  output logic [NREG-1:0]         Wrap
);

  localparam int SELW  = $clog2(NREG);
  localparam int NSLOT = 1 << SELW;

  logic [NREG-1:0][WIDTH-1:0]  regQ;
  logic [NSLOT-1:0][WIDTH-1:0] readQ;

  for (genvar g = 0; g < NREG; g++) begin : gCell
    reg_cell #(.WIDTH(WIDTH)) uCell (
      .Clk    (Clk),
      .Rst_n  (Rst_n),
      .En     (E & ~RegSel[g]),
      .FunSel (FunSel),
      .I      (I),
      .Q      (regQ[g]),
      .Wrap   (Wrap[g])
    );
    assign Zero[g] = ~|regQ[g];
  end

  // Pad the read array to a power of two so unused selects read as zero.
  for (genvar g = 0; g < NSLOT; g++) begin : gRead
    if (g < NREG) begin : gUsed
      assign readQ[g] = regQ[g];
    end else begin : gPad
      assign readQ[g] = '0;
    end
  end

  assign OutA = readQ[OutASel];
  assign OutB = readQ[OutBSel];

endmodule

// File: tb/tb_reg_file_param.sv
// Randomised and directed bench for reg_file_param (WIDTH=8, NREG=4) against an array model.
module tb_reg_file_param;
  localparam int W = 8;
  localparam int N = 4;

  logic         Clk = 1'b0;
  logic         Rst_n = 1'b1;
  logic         E = 1'b0;
  logic [W-1:0] I = '0;
  logic [N-1:0] RegSel = '1;
  logic [2:0]   FunSel = 3'b111;
  logic [1:0]   OutASel = '0;
  logic [1:0]   OutBSel = '0;
  logic [W-1:0] OutA, OutB;
  logic [N-1:0] Zero, Wrap;

  int checks = 0;
  int failures = 0;
  int m[N];
  bit w[N];
`ifdef REGFILE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  always #5 Clk = ~Clk;

  reg_file_param #(.WIDTH(W), .NREG(N)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .I(I), .E(E), .RegSel(RegSel), .FunSel(FunSel),
    .OutASel(OutASel), .OutBSel(OutBSel), .OutA(OutA), .OutB(OutB), .Zero(Zero), .Wrap(Wrap)
  );

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: each selected register follows the operation table with modular arithmetic.
  task automatic modelEdge(bit rst, bit e, logic [N-1:0] sel, logic [2:0] fs, logic [W-1:0] d);
    for (int r = 0; r < N; r++) begin
      if (!rst) begin
        m[r] = 0; w[r] = 0;
      end else if (e && !sel[r]) begin
        case (fs)
          3'd0: begin
            if (m[r] == 0) begin w[r] = 1; if (!SAT) m[r] = 255; end
            else m[r] = m[r] - 1;
          end
          3'd1: begin
            if (m[r] == 255) begin w[r] = 1; if (!SAT) m[r] = 0; end
            else m[r] = m[r] + 1;
          end
          3'd2: m[r] = int'(d);
          3'd3: begin m[r] = 0; w[r] = 0; end
          3'd4: m[r] = (m[r] * 2) % 256;
          3'd5: m[r] = m[r] / 2;
          3'd6: m[r] = (m[r] * 2) % 256 + m[r] / 128;
          default: ;
        endcase
      end
    end
  endtask

  task automatic step(bit rst, bit e, logic [N-1:0] sel, logic [2:0] fs, logic [W-1:0] d);
    Rst_n = rst; E = e; RegSel = sel; FunSel = fs; I = d;
    @(posedge Clk);
    modelEdge(rst, e, sel, fs, d);
    #1;
    Rst_n = 1'b1; E = 1'b0; RegSel = '1; FunSel = 3'b111;
  endtask

  task automatic checkAll(string tag);
    logic [N-1:0] ez, ew;
    for (int r = 0; r < N; r++) begin
      ez[r] = (m[r] == 0);
      ew[r] = w[r];
    end
    chk({tag, ".zero"}, 32'(Zero), 32'(ez));
    chk({tag, ".wrap"}, 32'(Wrap), 32'(ew));
    for (int r = 0; r < N; r++) begin
      OutASel = 2'(r);
      OutBSel = 2'(N - 1 - r);
      #1;
      chk({tag, ".outA"}, 32'(OutA), 32'(m[r]));
      chk({tag, ".outB"}, 32'(OutB), 32'(m[N - 1 - r]));
    end
  endtask

  task automatic rdA(string tag, int r, logic [W-1:0] exp);
    OutASel = 2'(r);
    #1;
    chk(tag, 32'(OutA), 32'(exp));
  endtask

  initial begin
    @(negedge Clk);
    step(1'b0, 1'b0, '1, 3'd7, '0);
    // 1: preload then reset overrides a pending LOAD to all registers
    for (int r = 0; r < N; r++) step(1'b1, 1'b1, ~(4'b1 << r), 3'd2, W'($urandom_range(1, 255)));
    step(1'b0, 1'b1, 4'b0000, 3'd2, 8'hAA);
    chk("rst.zero", 32'(Zero), 32'hF);
    chk("rst.wrap", 32'(Wrap), 32'h0);
    checkAll("rst");

    // 2: load and dual read
    step(1'b1, 1'b1, 4'b1110, 3'd2, 8'hBB);
    step(1'b1, 1'b1, 4'b1101, 3'd2, 8'hCC);
    OutASel = 2'd0; OutBSel = 2'd1; #1;
    chk("load.outA", 32'(OutA), 32'hBB);
    chk("load.outB", 32'(OutB), 32'hCC);
    chk("load.zero", 32'(Zero), 32'hC);

    // 3/4: INC at all-ones, DEC at zero, CLEAR drops the flag
    step(1'b1, 1'b1, 4'b1110, 3'd2, 8'hFF);
    step(1'b1, 1'b1, 4'b1110, 3'd1, 8'h00);
    rdA("incTop.r0", 0, SAT ? 8'hFF : 8'h00);
    chk("incTop.wrap0", 32'(Wrap[0]), 32'h1);
    step(1'b1, 1'b1, 4'b1101, 3'd2, 8'h00);
    step(1'b1, 1'b1, 4'b1101, 3'd0, 8'h00);
    rdA("decBot.r1", 1, SAT ? 8'h00 : 8'hFF);
    chk("decBot.wrap1", 32'(Wrap[1]), 32'h1);
    step(1'b1, 1'b1, 4'b1110, 3'd3, 8'h00);
    chk("clr.wrap0", 32'(Wrap[0]), 32'h0);
    checkAll("wrap");

    // 5: shift/rotate on 0x81
    step(1'b1, 1'b1, 4'b1011, 3'd2, 8'h81);
    step(1'b1, 1'b1, 4'b1011, 3'd4, 8'h00);
    rdA("shl", 2, 8'h02);
    step(1'b1, 1'b1, 4'b1011, 3'd2, 8'h81);
    step(1'b1, 1'b1, 4'b1011, 3'd5, 8'h00);
    rdA("shr", 2, 8'h40);
    step(1'b1, 1'b1, 4'b1011, 3'd2, 8'h81);
    step(1'b1, 1'b1, 4'b1011, 3'd6, 8'h00);
    rdA("rol", 2, 8'h03);
    chk("rol.wrap2", 32'(Wrap[2]), 32'h0);

    // 6: enable off, HOLD, and simultaneous INC
    step(1'b1, 1'b0, 4'b0000, 3'd3, 8'h00);
    checkAll("eOff");
    step(1'b1, 1'b1, 4'b0000, 3'd7, 8'h00);
    checkAll("hold");
    step(1'b1, 1'b1, 4'b0000, 3'd1, 8'h00);
    checkAll("incAll");

    // Random mix, biased toward 00/FF data so wrap edges are hit
    for (int t = 0; t < 400; t++) begin
      logic [W-1:0] d;
      case ($urandom_range(0, 3))
        0: d = 8'h00;
        1: d = 8'hFF;
        default: d = W'($urandom);
      endcase
      step(bit'($urandom_range(0, 29) != 0), bit'($urandom_range(0, 3) != 0),
           N'($urandom), 3'($urandom), d);
      checkAll("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
